// File: rtl/di_reg_slave_pkg.sv
// Shared definitions for the di_reg_slave endpoint: register offsets,
// FSM state encoding and the width of the wait-state counter.
package di_reg_slave_pkg;

  localparam logic [15:0] REG_CTRL    = 16'd0;
  localparam logic [15:0] REG_SCRATCH = 16'd1;
  localparam logic [15:0] REG_STATUS  = 16'd2;
  localparam logic [15:0] REG_COUNTER = 16'd3;
  localparam logic [15:0] REG_VERSION = 16'd4;

  // Wide enough for WAIT_CYCLES up to 255.
  localparam int WAIT_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/di_wait_timer.sv
// Wait-state timer: a start pulse arms an up-counter from zero, and done
// pulses for one cycle once WAIT_CYCLES cycles have elapsed since start.
module di_wait_timer
  import di_reg_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 8
) (
  input  logic if_clock,
  input  logic resetb,
  input  logic start,
  output logic done
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  running;

  assign done = running && (wait_cnt == LAST_CNT);

  // Count while running; stop on the terminal count or on reset.
  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      running  <= 1'b0;
      wait_cnt <= '0;
    end else if (start) begin
      running  <= 1'b1;
      wait_cnt <= '0;
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/di_reg_slave.sv
// Register slave endpoint on the di bus. Decodes the endpoint address,
// serves a small register bank, and stalls COUNTER reads with wait states.
// Optional sticky decode-error flag enabled by DI_REG_SLAVE_DECODE_ERR_EN.
module di_reg_slave
  import di_reg_slave_pkg::*;
#(
  parameter logic [15:0] EP_ADDR     = 16'h0001,
  parameter int          WAIT_CYCLES = 8,
  parameter logic [15:0] VERSION     = 16'h0100,
  parameter logic [15:0] SCRATCH_RST = 16'hA5A5
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic [15:0] diEpAddr,
  input  logic [15:0] diRegAddr,
  input  logic [15:0] diRegDataIn,
  input  logic        diWrite,
  input  logic        diRead,
  output logic [15:0] diRegDataOut,
  output logic        rdwr_ready,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_out,
  output logic        err
);

  state_t      state;
  state_t      next_state;
  logic        sel;
  logic        idle;
  logic        wr_strobe;
  logic        rd_strobe;
  logic        start_wait;
  logic        finish_wait;
  logic        wait_done;
  logic [15:0] rd_data;
  logic [15:0] read_value;
  logic [15:0] status_value;
  logic [15:0] ctrl_wr_value;
  logic [15:0] scratch;
  logic [15:0] counter;

  assign sel       = (diEpAddr == EP_ADDR);
  assign idle      = (state == ST_IDLE);
  assign wr_strobe = idle && sel && diWrite;
  assign rd_strobe = idle && sel && diRead && !diWrite;

  assign diRegDataOut = sel ? rd_data : 16'h0000;

  di_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_timer (
    .if_clock (if_clock),
    .resetb   (resetb),
    .start    (start_wait),
    .done     (wait_done)
  );

`ifdef DI_REG_SLAVE_DECODE_ERR_EN
  logic err_set;
  logic err_clr;

  assign err_set = idle && sel && (diWrite || diRead) &&
                   ((diRegAddr > REG_VERSION) ||
                    (diWrite && ((diRegAddr == REG_STATUS) || (diRegAddr == REG_VERSION))));
  assign err_clr = wr_strobe && (diRegAddr == REG_CTRL) && diRegDataIn[15];

  assign status_value  = {err, status_in[14:0]};
  assign ctrl_wr_value = {1'b0, diRegDataIn[14:0]};

  // Sticky error flag; a new error wins over a clear in the same cycle.
  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  assign err           = 1'b0;
  assign status_value  = status_in;
  assign ctrl_wr_value = diRegDataIn;
`endif

  // Read mux for the single-cycle registers.
  always_comb begin
    read_value = 16'h0000;
    case (diRegAddr)
      REG_CTRL:    read_value = ctrl_out;
      REG_SCRATCH: read_value = scratch;
      REG_STATUS:  read_value = status_value;
      REG_VERSION: read_value = VERSION;
      default:     read_value = 16'h0000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: COUNTER reads park in WAIT until the timer expires.
  always_comb begin
    next_state  = state;
    start_wait  = 1'b0;
    finish_wait = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_strobe && (diRegAddr == REG_COUNTER)) begin
          next_state = ST_WAIT;
          start_wait = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_done) begin
          next_state  = ST_IDLE;
          finish_wait = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Register bank updates from writes and from completed COUNTER reads.
  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      ctrl_out <= 16'h0000;
      scratch  <= SCRATCH_RST;
      counter  <= 16'h0000;
    end else begin
      if (wr_strobe) begin
        case (diRegAddr)
          REG_CTRL:    ctrl_out <= ctrl_wr_value;
          REG_SCRATCH: scratch  <= diRegDataIn;
          REG_COUNTER: counter  <= diRegDataIn;
          default:     ;
        endcase
      end
      if (finish_wait) begin
        counter <= counter + 16'h0001;
      end
    end
  end

  // Read data capture and ready pacing; data and ready rise together after a wait.
  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      rd_data    <= 16'h0000;
      rdwr_ready <= 1'b0;
    end else if (start_wait) begin
      rdwr_ready <= 1'b0;
    end else if (finish_wait) begin
      rd_data    <= counter;
      rdwr_ready <= 1'b1;
    end else if (idle) begin
      rdwr_ready <= 1'b1;
      if (rd_strobe) begin
        rd_data <= read_value;
      end
    end
  end

endmodule

// File: tb/tb_di_reg_slave.sv
// Self-checking bench for di_reg_slave: directed scenarios plus a randomized
// run compared against a transaction-level model of the register map.
// Build with DI_REG_SLAVE_DECODE_ERR_EN to exercise the error flag.
module tb_di_reg_slave;

  localparam logic [15:0] EP_ADDR     = 16'h0001;
  localparam int          WAIT_CYCLES = 8;
  localparam logic [15:0] VERSION     = 16'h0100;
  localparam logic [15:0] SCRATCH_RST = 16'hA5A5;

  logic        if_clock = 1'b0;
  logic        resetb;
  logic [15:0] diEpAddr;
  logic [15:0] diRegAddr;
  logic [15:0] diRegDataIn;
  logic        diWrite;
  logic        diRead;
  logic [15:0] diRegDataOut;
  logic        rdwr_ready;
  logic [15:0] status_in;
  logic [15:0] ctrl_out;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_ctrl;
  logic [15:0] m_scratch;
  logic [15:0] m_counter;
  logic        m_err;
  logic [15:0] m_last;

  di_reg_slave #(
    .EP_ADDR     (EP_ADDR),
    .WAIT_CYCLES (WAIT_CYCLES),
    .VERSION     (VERSION),
    .SCRATCH_RST (SCRATCH_RST)
  ) dut (
    .if_clock     (if_clock),
    .resetb       (resetb),
    .diEpAddr     (diEpAddr),
    .diRegAddr    (diRegAddr),
    .diRegDataIn  (diRegDataIn),
    .diWrite      (diWrite),
    .diRead       (diRead),
    .diRegDataOut (diRegDataOut),
    .rdwr_ready   (rdwr_ready),
    .status_in    (status_in),
    .ctrl_out     (ctrl_out),
    .err          (err)
  );

  always #5 if_clock = ~if_clock;

  task automatic model_reset();
    m_ctrl    = 16'h0000;
    m_scratch = SCRATCH_RST;
    m_counter = 16'h0000;
    m_err     = 1'b0;
    m_last    = 16'h0000;
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [15:0] data);
`ifdef DI_REG_SLAVE_DECODE_ERR_EN
    if (addr > 16'd4 || addr == 16'd2 || addr == 16'd4) m_err = 1'b1;
    else if (addr == 16'd0 && data[15]) m_err = 1'b0;
    if (addr == 16'd0) m_ctrl = data & 16'h7FFF;
`else
    if (addr == 16'd0) m_ctrl = data;
`endif
    if (addr == 16'd1) m_scratch = data;
    if (addr == 16'd3) m_counter = data;
  endtask

  task automatic model_read(input logic [15:0] addr, input logic [15:0] st,
                            output logic [15:0] exp);
    case (addr)
      16'd0: exp = m_ctrl;
      16'd1: exp = m_scratch;
`ifdef DI_REG_SLAVE_DECODE_ERR_EN
      16'd2: exp = {m_err, st[14:0]};
`else
      16'd2: exp = st;
`endif
      16'd3: begin
        exp = m_counter;
        m_counter = m_counter + 16'd1;
      end
      16'd4: exp = VERSION;
      default: exp = 16'h0000;
    endcase
`ifdef DI_REG_SLAVE_DECODE_ERR_EN
    if (addr > 16'd4) m_err = 1'b1;
`endif
    m_last = exp;
  endtask

  task automatic drive_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge if_clock);
    diRegAddr   = addr;
    diRegDataIn = data;
    diWrite     = 1'b1;
    @(negedge if_clock);
    diWrite = 1'b0;
  endtask

  // Issue a read strobe, then count cycles with ready low (bounded).
  task automatic drive_read(input logic [15:0] addr, output logic [15:0] data,
                            output int low_cycles);
    @(negedge if_clock);
    diRegAddr = addr;
    diRead    = 1'b1;
    @(negedge if_clock);
    diRead = 1'b0;
    low_cycles = 0;
    while (!rdwr_ready && low_cycles < 100) begin
      low_cycles++;
      @(negedge if_clock);
    end
    data = diRegDataOut;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int lc;
    resetb = 1'b0;
    repeat (3) @(negedge if_clock);
    n_cmp++; if (rdwr_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b expected 0", rdwr_ready); end
    n_cmp++; if (ctrl_out !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_ctrl: got %h expected 0000", ctrl_out); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (diRegDataOut !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_data: got %h expected 0000", diRegDataOut); end
    resetb = 1'b1;
    model_reset();
    @(negedge if_clock);
    n_cmp++; if (rdwr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_ready: got %b expected 1", rdwr_ready); end
    drive_read(16'd1, d, lc);
    n_cmp++; if (d !== SCRATCH_RST) begin n_err++; $display("[TB] FAIL scratch_rst: got %h expected %h", d, SCRATCH_RST); end
    m_last = d;
  endtask

  task automatic test_ctrl_rw();
    logic [15:0] d;
    logic [15:0] exp;
    int lc;
    drive_write(16'd0, 16'h1234);
    model_write(16'd0, 16'h1234);
    n_cmp++; if (ctrl_out !== 16'h1234) begin n_err++; $display("[TB] FAIL ctrl_out: got %h expected 1234", ctrl_out); end
    n_cmp++; if (rdwr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL write_ready: got %b expected 1", rdwr_ready); end
    drive_read(16'd0, d, lc);
    model_read(16'd0, status_in, exp);
    n_cmp++; if (d !== 16'h1234) begin n_err++; $display("[TB] FAIL ctrl_read: got %h expected 1234", d); end
    n_cmp++; if (lc !== 0) begin n_err++; $display("[TB] FAIL ctrl_read_wait: got %0d expected 0", lc); end
  endtask

  task automatic test_counter_wait();
    logic [15:0] d;
    logic [15:0] exp;
    int lc;
    for (int i = 0; i < 2; i++) begin
      drive_read(16'd3, d, lc);
      model_read(16'd3, status_in, exp);
      n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL counter_read%0d: got %h expected %h", i, d, exp); end
      n_cmp++; if (lc !== WAIT_CYCLES) begin n_err++; $display("[TB] FAIL counter_wait%0d: got %0d expected %0d", i, lc, WAIT_CYCLES); end
    end
  endtask

  task automatic test_counter_wrap();
    logic [15:0] d;
    logic [15:0] exp;
    int lc;
    drive_write(16'd3, 16'hFFFF);
    model_write(16'd3, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      drive_read(16'd3, d, lc);
      model_read(16'd3, status_in, exp);
      n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL wrap_read%0d: got %h expected %h", i, d, exp); end
    end
  endtask

  task automatic test_foreign_ep();
    logic [15:0] d;
    logic [15:0] exp;
    int lc;
    diEpAddr = EP_ADDR + 16'd1;
    drive_write(16'd1, 16'h0000);
    n_cmp++; if (diRegDataOut !== 16'h0000) begin n_err++; $display("[TB] FAIL foreign_data: got %h expected 0000", diRegDataOut); end
    drive_read(16'd3, d, lc);
    n_cmp++; if (lc !== 0) begin n_err++; $display("[TB] FAIL foreign_wait: got %0d expected 0", lc); end
    diEpAddr = EP_ADDR;
    drive_read(16'd1, d, lc);
    model_read(16'd1, status_in, exp);
    n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL foreign_scratch: got %h expected %h", d, exp); end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] d;
    logic [15:0] exp;
    int lc;
    drive_write(16'd3, 16'h0000);
    model_write(16'd3, 16'h0000);
    @(negedge if_clock);
    diRegAddr = 16'd3;
    diRead    = 1'b1;
    @(negedge if_clock);
    diRead = 1'b0;
    @(negedge if_clock);
    @(negedge if_clock);
    resetb = 1'b0;
    @(negedge if_clock);
    n_cmp++; if (rdwr_ready !== 1'b0) begin n_err++; $display("[TB] FAIL abort_ready_low: got %b expected 0", rdwr_ready); end
    resetb = 1'b1;
    model_reset();
    @(negedge if_clock);
    n_cmp++; if (rdwr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort_ready_high: got %b expected 1", rdwr_ready); end
    drive_read(16'd3, d, lc);
    model_read(16'd3, status_in, exp);
    n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL abort_counter: got %h expected %h", d, exp); end
    n_cmp++; if (lc !== WAIT_CYCLES) begin n_err++; $display("[TB] FAIL abort_wait: got %0d expected %0d", lc, WAIT_CYCLES); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    logic [15:0] exp;
    logic [15:0] wd;
    int lc;
    wd = 16'($urandom);
    @(negedge if_clock);
    diRegAddr   = 16'd1;
    diRegDataIn = wd;
    diWrite     = 1'b1;
    diRead      = 1'b1;
    @(negedge if_clock);
    diWrite = 1'b0;
    diRead  = 1'b0;
    model_write(16'd1, wd);
    n_cmp++; if (diRegDataOut !== m_last) begin n_err++; $display("[TB] FAIL collision_rd: got %h expected %h", diRegDataOut, m_last); end
    drive_read(16'd1, d, lc);
    model_read(16'd1, status_in, exp);
    n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL collision_wr: got %h expected %h", d, exp); end
  endtask

  task automatic test_decode();
    logic [15:0] d;
    logic [15:0] exp;
    int lc;
    drive_read(16'd7, d, lc);
    model_read(16'd7, status_in, exp);
    n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL unmapped_read: got %h expected %h", d, exp); end
    n_cmp++; if (err !== m_err) begin n_err++; $display("[TB] FAIL err_set: got %b expected %b", err, m_err); end
    status_in = 16'h7ABC;
    drive_read(16'd2, d, lc);
    model_read(16'd2, status_in, exp);
    n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL status_read: got %h expected %h", d, exp); end
    drive_write(16'd0, 16'h8000);
    model_write(16'd0, 16'h8000);
    n_cmp++; if (err !== m_err) begin n_err++; $display("[TB] FAIL err_clear: got %b expected %b", err, m_err); end
    n_cmp++; if (ctrl_out !== m_ctrl) begin n_err++; $display("[TB] FAIL ctrl_bit15: got %h expected %h", ctrl_out, m_ctrl); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] exp;
    logic [15:0] addr;
    logic [15:0] wd;
    int lc;
    for (int i = 0; i < 60; i++) begin
      addr      = 16'($urandom_range(0, 7));
      status_in = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        wd = 16'($urandom);
        drive_write(addr, wd);
        model_write(addr, wd);
        n_cmp++; if (ctrl_out !== m_ctrl) begin n_err++; $display("[TB] FAIL rand_ctrl[%0d]: got %h expected %h", i, ctrl_out, m_ctrl); end
      end else begin
        drive_read(addr, d, lc);
        model_read(addr, status_in, exp);
        n_cmp++; if (d !== exp) begin n_err++; $display("[TB] FAIL rand_read[%0d] addr %0d: got %h expected %h", i, addr, d, exp); end
        n_cmp++; if (lc !== ((addr == 16'd3) ? WAIT_CYCLES : 0)) begin n_err++; $display("[TB] FAIL rand_wait[%0d]: got %0d", i, lc); end
      end
      n_cmp++; if (err !== m_err) begin n_err++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", i, err, m_err); end
    end
  endtask

  initial begin
    resetb      = 1'b0;
    diEpAddr    = EP_ADDR;
    diRegAddr   = 16'h0000;
    diRegDataIn = 16'h0000;
    diWrite     = 1'b0;
    diRead      = 1'b0;
    status_in   = 16'h0000;
    model_reset();
    test_reset();
    test_ctrl_rw();
    test_counter_wait();
    test_counter_wrap();
    test_foreign_ep();
    test_reset_mid_wait();
    test_collision();
    test_decode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
